// File: rtl/sw_word_entry.sv
// Switch-driven 32-bit word entry: a debounced step button latches one byte per press, then an
// address, then raises a register-file write request until the CPU acknowledges it.
module sw_word_entry #(
   parameter int unsigned DB_COUNT   = 500000,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clka,
   input  logic                  rsta,
   input  logic [7:0]            swa,
   input  logic                  keya,
   input  logic                  clra,
   input  logic                  acka,
   output logic                  wea,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [31:0]           douta,
   output logic [2:0]            stagea,
   output logic                  busya
);

   localparam int unsigned     CntW   = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DB_COUNT - 1);

   typedef enum logic [2:0] {
      StB0    = 3'd0,
      StB1    = 3'd1,
      StB2    = 3'd2,
      StB3    = 3'd3,
      StAddr  = 3'd4,
      StWrite = 3'd5
   } state_t;

   logic            key_meta_q, key_s_q;
   logic            db_level_q, db_level_d, db_prev_q;
   logic [CntW-1:0] db_cnt_q, db_cnt_d;
   logic            press;

   state_t                state_q, state_d;
   logic [31:0]           data_q, data_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] sw_addr;

   generate
      if (ADDR_WIDTH <= 8) begin : g_addr_narrow
         assign sw_addr = swa[ADDR_WIDTH-1:0];
      end else begin : g_addr_wide
         assign sw_addr = {{(ADDR_WIDTH - 8){1'b0}}, swa};
      end
   endgenerate

   // Level only flips after key_s has disagreed with it for DB_COUNT consecutive edges.
   always_comb begin
      db_cnt_d   = '0;
      db_level_d = db_level_q;
      if (key_s_q != db_level_q) begin
         if (db_cnt_q == CntMax) begin
            db_level_d = ~db_level_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   assign press = db_level_q & ~db_prev_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      addr_d  = addr_q;
      if (clra && (state_q != StWrite)) begin
         state_d = StB0;
         data_d  = '0;
         addr_d  = '0;
      end else begin
         case (state_q)
            StB0, StB1, StB2, StB3: begin
               if (press) begin
                  data_d[{state_q[1:0], 3'b000} +: 8] = swa;
                  state_d = state_t'(state_q + 3'd1);
               end
            end
            StAddr: begin
               if (press) begin
                  addr_d  = sw_addr;
                  state_d = StWrite;
               end
            end
            StWrite: begin
               if (acka) begin
                  state_d = StB0;
               end
            end
            default: state_d = StB0;
         endcase
      end
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         key_meta_q <= 1'b0;
         key_s_q    <= 1'b0;
         db_level_q <= 1'b0;
         db_prev_q  <= 1'b0;
         db_cnt_q   <= '0;
         state_q    <= StB0;
         data_q     <= '0;
         addr_q     <= '0;
      end else begin
         key_meta_q <= keya;
         key_s_q    <= key_meta_q;
         db_level_q <= db_level_d;
         db_prev_q  <= db_level_q;
         db_cnt_q   <= db_cnt_d;
         state_q    <= state_d;
         data_q     <= data_d;
         addr_q     <= addr_d;
      end
   end

   assign wea    = (state_q == StWrite);
   assign busya  = (state_q == StWrite);
   assign stagea = state_q;
   assign douta  = data_q;
   assign addra  = addr_q;

endmodule

// File: tb/tb_sw_word_entry.sv
// Scoreboard bench for sw_word_entry: stimulus queues each expected stage transition, a negedge
// monitor pops and checks it whenever stagea moves, and flags any unexpected output activity.
module tb_sw_word_entry;

   localparam int unsigned DbCount = 4;
   localparam int unsigned AddrW   = 5;

   logic             clka = 1'b0;
   logic             rsta, keya, clra, acka;
   logic [7:0]       swa;
   logic             wea, busya;
   logic [AddrW-1:0] addra;
   logic [31:0]      douta;
   logic [2:0]       stagea;

   typedef struct {
      int          cyc;
      logic [2:0]  stage;
      logic [31:0] dout;
      logic [4:0]  addr;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   bit   prev_valid = 1'b0;
   logic [2:0]  prev_stage;
   logic [31:0] prev_dout;
   logic [4:0]  prev_addr;

   sw_word_entry #(
      .DB_COUNT   (DbCount),
      .ADDR_WIDTH (AddrW)
   ) dut (
      .clka   (clka),
      .rsta   (rsta),
      .swa    (swa),
      .keya   (keya),
      .clra   (clra),
      .acka   (acka),
      .wea    (wea),
      .addra  (addra),
      .douta  (douta),
      .stagea (stagea),
      .busya  (busya)
   );

   always #5 clka = ~clka;
   always @(posedge clka) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [2:0] st, input logic [31:0] d,
                       input logic [4:0] a);
      exp_t e;
      e.cyc = c; e.stage = st; e.dout = d; e.addr = a;
      exp_q.push_back(e);
   endtask

   // Clean press: stage change expected 7 cycles after keya rises (DB_COUNT + 3).
   task automatic press(input logic [7:0] sw, input logic [2:0] st, input logic [31:0] d,
                        input logic [4:0] a);
      @(negedge clka);
      swa  = sw;
      keya = 1'b1;
      push(cyc + 7, st, d, a);
      repeat (10) @(negedge clka);
      keya = 1'b0;
      repeat (10) @(negedge clka);
   endtask

   always @(negedge clka) begin
      if (mon_en) begin
         if (!prev_valid) begin
            prev_valid = 1'b1;
         end else begin
            chk("wea_vs_stage", wea, (stagea == 3'd5));
            chk("busy_vs_stage", busya, (stagea == 3'd5));
            if (stagea !== prev_stage) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_stage_change", stagea, prev_stage);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("stage", stagea, e.stage);
                  chk("stage_time", cyc, e.cyc);
                  chk("douta", douta, e.dout);
                  chk("addra", addra, e.addr);
               end
            end else begin
               chk("douta_stable", douta, prev_dout);
               chk("addra_stable", addra, prev_addr);
            end
         end
         prev_stage = stagea;
         prev_dout  = douta;
         prev_addr  = addra;
      end
   end

   initial begin
      rsta = 1'b1; keya = 1'b0; clra = 1'b0; acka = 1'b0; swa = 8'h00;
      repeat (3) @(negedge clka);
      chk("rst_wea", wea, 1'b0);
      chk("rst_busy", busya, 1'b0);
      chk("rst_stage", stagea, 3'd0);
      chk("rst_douta", douta, 32'h0);
      chk("rst_addra", addra, 5'h0);
      rsta   = 1'b0;
      mon_en = 1'b1;
      repeat (20) @(negedge clka);

      // Bouncing key: every-cycle toggles must never qualify as a press.
      for (int i = 0; i < 30; i++) begin
         keya = ~keya;
         @(negedge clka);
      end
      keya = 1'b0;
      repeat (12) @(negedge clka);

      press(8'h78, 3'd1, 32'h0000_0078, 5'h00);
      press(8'h56, 3'd2, 32'h0000_5678, 5'h00);
      press(8'h34, 3'd3, 32'h0034_5678, 5'h00);
      press(8'h12, 3'd4, 32'h1234_5678, 5'h00);
      // Address press; acka raised so the third wea cycle ends the write.
      @(negedge clka);
      swa  = 8'h0A;
      keya = 1'b1;
      push(cyc + 7, 3'd5, 32'h1234_5678, 5'h0A);
      repeat (9) @(negedge clka);
      acka = 1'b1;
      push(cyc + 1, 3'd0, 32'h1234_5678, 5'h0A);
      @(negedge clka);
      acka = 1'b0;
      keya = 1'b0;
      repeat (10) @(negedge clka);

      press(8'hAA, 3'd1, 32'h1234_56AA, 5'h0A);
      press(8'hBB, 3'd2, 32'h1234_BBAA, 5'h0A);
      clra = 1'b1;
      push(cyc + 1, 3'd0, 32'h0, 5'h00);
      @(negedge clka);
      clra = 1'b0;
      repeat (3) @(negedge clka);
      press(8'h11, 3'd1, 32'h0000_0011, 5'h00);

      press(8'h22, 3'd2, 32'h0000_2211, 5'h00);
      press(8'h33, 3'd3, 32'h0033_2211, 5'h00);
      press(8'h44, 3'd4, 32'h4433_2211, 5'h00);
      press(8'h1F, 3'd5, 32'h4433_2211, 5'h1F);
      // Press and clra during S_WRITE are both ignored.
      @(negedge clka);
      swa  = 8'hEE;
      keya = 1'b1;
      repeat (10) @(negedge clka);
      keya = 1'b0;
      clra = 1'b1;
      @(negedge clka);
      clra = 1'b0;
      repeat (10) @(negedge clka);
      acka = 1'b1;
      push(cyc + 1, 3'd0, 32'h4433_2211, 5'h1F);
      @(negedge clka);
      acka = 1'b0;
      repeat (3) @(negedge clka);

      press(8'h01, 3'd1, 32'h4433_2201, 5'h1F);
      press(8'h02, 3'd2, 32'h4433_0201, 5'h1F);
      press(8'h03, 3'd3, 32'h4403_0201, 5'h1F);
      press(8'h04, 3'd4, 32'h0403_0201, 5'h1F);
      press(8'h03, 3'd5, 32'h0403_0201, 5'h03);
      // Key held high through a reset issued mid-write.
      @(negedge clka);
      keya = 1'b1;
      swa  = 8'h5A;
      repeat (12) @(negedge clka);
      rsta = 1'b1;
      push(cyc + 1, 3'd0, 32'h0, 5'h00);
      repeat (2) @(negedge clka);
      rsta = 1'b0;
      push(cyc + 7, 3'd1, 32'h0000_005A, 5'h00);
      repeat (30) @(negedge clka);
      keya = 1'b0;
      repeat (15) @(negedge clka);

      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
